// File: rtl/circ_queue_ctrl.sv
// ---------------------------------------------------------------------------
// circ_queue_ctrl
//   Head/tail pointer controller for the core's circular queues (ROB, IQ,
//   LSQ, fetch buffer). It holds no payload; the external storage is written
//   at enq_idx when enq_fire is high and read at deq_idx.
//
//   Handshake: a transfer happens on a side exactly when valid & ready are
//   both high in a cycle (that side's *_fire). Ready/valid driven here depend
//   only on registered pointer state, never on the partner's valid/ready, so
//   there are no combinational loops. The producer may raise and drop
//   enq_valid at will, and the consumer may do the same with deq_ready.
//
//   Optional feature (macro CIRC_QUEUE_CTRL_OCC_EN): adds the output port
//   occ = tail - head, the current entry count (0..DEPTH).
//
// Parameters
//   PTR_WIDTH  index width, DEPTH = 2**PTR_WIDTH entries (1..8)
// Ports
//   clk        clock, rising-edge state updates
//   rst_aL     asynchronous active-low reset
//   enq_valid  producer offers an entry
//   enq_ready  queue can accept (= !full)
//   enq_fire   enq_valid & enq_ready, write enable at enq_idx
//   enq_idx    tail index (next slot to write)
//   deq_valid  oldest entry available (= !empty)
//   deq_ready  consumer takes the oldest entry
//   deq_fire   deq_valid & deq_ready
//   deq_idx    head index (oldest entry)
//   flush      synchronous discard of all entries
//   full       DEPTH entries held
//   empty      no entries held
//   occ        (CIRC_QUEUE_CTRL_OCC_EN only) entry count
// ---------------------------------------------------------------------------
module circ_queue_ctrl #(
  parameter int PTR_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_aL,
  input  logic                 enq_valid,
  output logic                 enq_ready,
  output logic                 enq_fire,
  output logic [PTR_WIDTH-1:0] enq_idx,
  output logic                 deq_valid,
  input  logic                 deq_ready,
  output logic                 deq_fire,
  output logic [PTR_WIDTH-1:0] deq_idx,
  input  logic                 flush,
  output logic                 full,
  output logic                 empty
`ifdef CIRC_QUEUE_CTRL_OCC_EN
  ,
  output logic [PTR_WIDTH:0]   occ
`endif
);

  localparam logic [PTR_WIDTH:0] PTR_ONE  = {{PTR_WIDTH{1'b0}}, 1'b1};
  localparam logic [PTR_WIDTH:0] PTR_ZERO = '0;

  // Pointers are {wrap, idx}. The extra wrap bit separates full from empty
  // when the index fields are equal.
  logic [PTR_WIDTH:0] tail;
  logic [PTR_WIDTH:0] head;
  logic [PTR_WIDTH:0] tail_inc;
  logic [PTR_WIDTH:0] head_inc;

  // Adding modulo 2**(PTR_WIDTH+1) moves idx DEPTH-1 to 0 and toggles wrap
  assign tail_inc = tail + PTR_ONE;
  assign head_inc = head + PTR_ONE;

  // Status comes purely from registered state. There is no bypass in either
  // direction: a full queue refuses an enqueue even while a dequeue fires,
  // and an empty queue offers nothing even while an enqueue fires.
  assign empty     = (head == tail);
  assign full      = (head[PTR_WIDTH-1:0] == tail[PTR_WIDTH-1:0]) &&
                     (head[PTR_WIDTH] != tail[PTR_WIDTH]);
  assign enq_ready = ~full;
  assign deq_valid = ~empty;
  assign enq_fire  = enq_valid & enq_ready;
  assign deq_fire  = deq_valid & deq_ready;
  assign enq_idx   = tail[PTR_WIDTH-1:0];
  assign deq_idx   = head[PTR_WIDTH-1:0];

  // Flush beats both fires. The fire outputs still follow the handshake in a
  // flush cycle, and whatever gets written that cycle is thrown away.
  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      tail <= PTR_ZERO;
    end else if (flush) begin
      tail <= PTR_ZERO;
    end else if (enq_fire) begin
      tail <= tail_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      head <= PTR_ZERO;
    end else if (flush) begin
      head <= PTR_ZERO;
    end else if (deq_fire) begin
      head <= head_inc;
    end
  end

`ifdef CIRC_QUEUE_CTRL_OCC_EN
  // The wrap bit makes the modular difference the exact count, so it always
  // falls within 0..DEPTH.
  assign occ = tail - head;
`else
  // No occupancy output in this build. The pointer logic is the same.
`endif

endmodule

// File: tb/tb_circ_queue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_circ_queue_ctrl
//   Directed and random bench for circ_queue_ctrl at PTR_WIDTH=2 (DEPTH=4).
//   An independent pointer model predicts the status and index outputs. A
//   scoreboard queue records each accepted enqueue index. Each dequeue must
//   return those indices in FIFO order.
// ---------------------------------------------------------------------------
module tb_circ_queue_ctrl;

  localparam int P = 2;
  localparam int W = P;

  // clock / reset
  logic clk = 1'b0;
  logic rst_aL = 1'b0;
  always #5 clk = ~clk;

  logic         enq_valid = 1'b0;
  logic         deq_ready = 1'b0;
  logic         flush = 1'b0;
  logic         enq_ready, enq_fire, deq_valid, deq_fire, full, empty;
  logic [P-1:0] enq_idx, deq_idx;
`ifdef CIRC_QUEUE_CTRL_OCC_EN
  logic [P:0]   occ;
`endif

  circ_queue_ctrl #(.PTR_WIDTH(P)) dut (
    .clk       (clk),
    .rst_aL    (rst_aL),
    .enq_valid (enq_valid),
    .enq_ready (enq_ready),
    .enq_fire  (enq_fire),
    .enq_idx   (enq_idx),
    .deq_valid (deq_valid),
    .deq_ready (deq_ready),
    .deq_fire  (deq_fire),
    .deq_idx   (deq_idx),
    .flush     (flush),
    .full      (full),
    .empty     (empty)
`ifdef CIRC_QUEUE_CTRL_OCC_EN
    ,
    .occ       (occ)
`endif
  );

  // model and scoreboard
  logic [P:0]   m_tail = '0;
  logic [P:0]   m_head = '0;
  logic [W-1:0] exp_q[$];
  int           total  = 0;
  int           passed = 0;
  int           failed = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_full();
    return (m_tail[P-1:0] == m_head[P-1:0]) && (m_tail[P] != m_head[P]);
  endfunction

  function automatic logic m_empty();
    return m_tail == m_head;
  endfunction

  // Check every output against the model
  task automatic chk_outputs(input string tag);
    logic [P:0] m_occ;
    m_occ = m_tail - m_head;
    chk({tag, ".empty"},     16'(empty),     16'(m_empty()));
    chk({tag, ".full"},      16'(full),      16'(m_full()));
    chk({tag, ".enq_ready"}, 16'(enq_ready), 16'(!m_full()));
    chk({tag, ".deq_valid"}, 16'(deq_valid), 16'(!m_empty()));
    chk({tag, ".enq_idx"},   16'(enq_idx),   16'(m_tail[P-1:0]));
    chk({tag, ".deq_idx"},   16'(deq_idx),   16'(m_head[P-1:0]));
    chk({tag, ".enq_fire"},  16'(enq_fire),  16'(enq_valid & !m_full()));
    chk({tag, ".deq_fire"},  16'(deq_fire),  16'(deq_ready & !m_empty()));
`ifdef CIRC_QUEUE_CTRL_OCC_EN
    chk({tag, ".occ"},       16'(occ),       16'(m_occ));
`else
    chk({tag, ".occ_range"}, 16'(m_occ <= (P+1)'(1 << P)), 16'(1));
`endif
  endtask

  // Driver: apply inputs after an edge, check at the negedge, then advance
  // the model at the next posedge.
  task automatic step(input string tag, input logic ev, input logic dr, input logic fl);
    logic e_fire, d_fire;
    enq_valid = ev;
    deq_ready = dr;
    flush     = fl;
    @(negedge clk);
    chk_outputs(tag);
    e_fire = ev & !m_full();
    d_fire = dr & !m_empty();
    if (e_fire) exp_q.push_back(m_tail[P-1:0]);
    if (deq_fire) begin
      if (exp_q.size() == 0) chk({tag, ".sb_underflow"}, 16'(exp_q.size()), 16'(1));
      else chk({tag, ".sb_deq_idx"}, 16'(deq_idx), 16'(exp_q.pop_front()));
    end
    @(posedge clk);
    if (fl) begin
      m_tail = '0;
      m_head = '0;
      exp_q.delete();
    end else begin
      if (e_fire) m_tail = m_tail + 1'b1;
      if (d_fire) m_head = m_head + 1'b1;
    end
    #1;
  endtask

  initial begin
    // 1: reset state, asserted from time zero
    #2;
    chk_outputs("reset0");
    repeat (2) @(posedge clk);
    #1;
    rst_aL = 1'b1;

    // 2: fill
    for (int i = 0; i < 4; i++) step($sformatf("fill%0d", i), 1'b1, 1'b0, 1'b0);
    chk("fill.full", 16'(full), 16'(1));
    chk("fill.enq_idx_wrapped", 16'(enq_idx), 16'(0));
    step("fill_extra", 1'b1, 1'b0, 1'b0);

    // 3: drain and wrap
    for (int i = 0; i < 4; i++) step($sformatf("drain%0d", i), 1'b0, 1'b1, 1'b0);
    chk("drain.empty", 16'(empty), 16'(1));
    chk("drain.head_wrap", 16'(m_head), 16'(3'b100));
    step("drain_extra", 1'b0, 1'b1, 1'b0);

    // 4: simultaneous at occupancy 2
    step("sim_pre0", 1'b1, 1'b0, 1'b0);
    step("sim_pre1", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      step($sformatf("sim%0d", i), 1'b1, 1'b1, 1'b0);
      chk($sformatf("sim%0d.not_full", i), 16'(full), 16'(0));
      chk($sformatf("sim%0d.not_empty", i), 16'(empty), 16'(0));
    end

    // 5: full and empty boundaries with both sides active
    step("to_full0", 1'b1, 1'b0, 1'b0);
    step("to_full1", 1'b1, 1'b0, 1'b0);
    chk("edge.full", 16'(full), 16'(1));
    step("full_both", 1'b1, 1'b1, 1'b0);
    chk("full_both.occ3", 16'(m_tail - m_head), 16'(3));
    for (int i = 0; i < 3; i++) step($sformatf("to_empty%0d", i), 1'b0, 1'b1, 1'b0);
    chk("edge.empty", 16'(empty), 16'(1));
    step("empty_both", 1'b1, 1'b1, 1'b0);
    chk("empty_both.occ1", 16'(m_tail - m_head), 16'(1));

    // 6: flush with both fires pending at occupancy 3
    step("pre_flush0", 1'b1, 1'b0, 1'b0);
    step("pre_flush1", 1'b1, 1'b0, 1'b0);
    step("flush", 1'b1, 1'b1, 1'b1);
    step("post_flush", 1'b0, 1'b0, 1'b0);
    chk("post_flush.empty", 16'(empty), 16'(1));

    // random traffic
    for (int i = 0; i < 300; i++)
      step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 19) == 0));

    // asynchronous reset in the middle of the low phase
    step("pre_rst0", 1'b1, 1'b0, 1'b0);
    step("pre_rst1", 1'b1, 1'b1, 1'b0);
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    @(negedge clk);
    #2;
    rst_aL = 1'b0;
    #1;
    m_tail = '0;
    m_head = '0;
    exp_q.delete();
    chk_outputs("async_rst");
    @(posedge clk);
    @(negedge clk);
    rst_aL = 1'b1;
    @(posedge clk);
    #1;
    step("after_rst", 1'b1, 1'b0, 1'b0);
    step("after_rst1", 1'b0, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "timeout");
  end

endmodule
